// File: rtl/smpl_cnt_chk_if.sv
// Expected-count push channel and per-triangle result bus of smpl_cnt_chk.
// The master drives expected counts and consumes results; the slave is the checker.
interface smpl_cnt_chk_if #(
  parameter int CNT_W = 32
) ();
  logic             exp_valid;
  logic [CNT_W-1:0] exp_cnt;
  logic             exp_ready;
  logic             res_valid;
  logic [CNT_W-1:0] res_cnt;
  logic [CNT_W-1:0] res_exp;
  logic             res_match;
  logic             res_underflow;

  modport master (
    output exp_valid, exp_cnt,
    input  exp_ready, res_valid, res_cnt, res_exp, res_match, res_underflow
  );

  modport slave (
    input  exp_valid, exp_cnt,
    output exp_ready, res_valid, res_cnt, res_exp, res_match, res_underflow
  );
endinterface

// File: rtl/smpl_cnt_chk.sv
// Per-triangle hit-count checker: finds triangle boundaries on a delayed triangle bus,
// counts lane hits and compares each closed count with a queued expectation.
// Optional error counter enabled by defining SMPL_CNT_CHK_ERR_CNT_EN.
module smpl_cnt_chk #(
  parameter int SIGFIG     = 24,
  parameter int VERTS      = 3,
  parameter int AXIS       = 3,
  parameter int LANES      = 2,
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W      = 32,
  parameter int EXP_DEPTH  = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
  input  logic                                          validSamp_R16H,
  input  logic [LANES-1:0]                              hit_valid_R18H,
  input  logic                                          flush,
  smpl_cnt_chk_if.slave                                 bus,
  output logic                                          err_sticky,
  output logic [15:0]                                   err_cnt,
  output logic [31:0]                                   tri_cnt
);

  localparam int TRI_W = SIGFIG * VERTS * AXIS;
  localparam int PTR_W = (EXP_DEPTH > 1) ? $clog2(EXP_DEPTH) : 1;
  // Four spare bits hold up to 8 lanes of hits added to a full-scale count.
  localparam int SUM_W = CNT_W + 4;
  localparam logic [SUM_W-1:0] CNT_MAX_EXT = {4'b0, {CNT_W{1'b1}}};
  localparam logic [PTR_W:0]   FIFO_FULL   = (PTR_W + 1)'(EXP_DEPTH);

  typedef logic [TRI_W-1:0] tri_t;
  typedef enum logic {ST_IDLE, ST_OPEN} state_t;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [SUM_W-1:0] v);
    if (v > CNT_MAX_EXT) sat_cnt = '1;
    else                 sat_cnt = v[CNT_W-1:0];
  endfunction

  // Triangle and sample-valid delay lines
  genvar gi;
  generate
    for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_dly
      tri_t stg_d;
      tri_t stg_q;
      logic vld_d;
      logic vld_q;

      if (gi == 0) begin : g_head
        always_comb begin
          stg_d = tri_t'(tri_R16S);
          vld_d = validSamp_R16H;
        end
      end else begin : g_tail
        always_comb begin
          stg_d = g_dly[gi-1].stg_q;
          vld_d = g_dly[gi-1].vld_q;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          stg_q <= '0;
          vld_q <= 1'b0;
        end else begin
          stg_q <= stg_d;
          vld_q <= vld_d;
        end
      end
    end
  endgenerate

  tri_t tri_RnnS;
  tri_t tri_Rn1S;
  logic validSamp_RnnH;
  logic boundary;

  assign tri_RnnS       = g_dly[PIPE_DEPTH-1].stg_q;
  assign tri_Rn1S       = g_dly[PIPE_DEPTH-2].stg_q;
  assign validSamp_RnnH = g_dly[PIPE_DEPTH-1].vld_q;
  assign boundary       = (tri_Rn1S != tri_RnnS) && validSamp_RnnH;

  logic [SUM_W-1:0] hit_pop;

  always_comb begin
    hit_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      hit_pop = hit_pop + SUM_W'(hit_valid_R18H[i]);
    end
  end

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             close;
  logic [CNT_W-1:0] close_cnt;

  // A boundary closes the old triangle with its prior count; this cycle's hits open the new one.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    close     = 1'b0;
    close_cnt = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (boundary) begin
          state_d = ST_OPEN;
          cnt_d   = sat_cnt(hit_pop);
        end
      end
      ST_OPEN: begin
        if (boundary) begin
          close     = 1'b1;
          close_cnt = cnt_q;
          cnt_d     = sat_cnt(hit_pop);
        end else if (flush) begin
          close     = 1'b1;
          close_cnt = sat_cnt(SUM_W'(cnt_q) + hit_pop);
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = sat_cnt(SUM_W'(cnt_q) + hit_pop);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Expected-count FIFO
  logic [CNT_W-1:0] mem_q [EXP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [PTR_W:0]   fill_q;
  logic [PTR_W:0]   fill_d;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] head;

  assign fifo_full     = (fill_q == FIFO_FULL);
  assign fifo_empty    = (fill_q == '0);
  assign bus.exp_ready = rst && !fifo_full;
  assign push          = bus.exp_valid && bus.exp_ready;
  assign pop           = close && !fifo_empty;
  assign head          = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    fill_d   = fill_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.exp_cnt;
    end
  end

  // Result and error bookkeeping
  logic             res_valid_q;
  logic             res_valid_d;
  logic [CNT_W-1:0] res_cnt_q;
  logic [CNT_W-1:0] res_cnt_d;
  logic [CNT_W-1:0] res_exp_q;
  logic [CNT_W-1:0] res_exp_d;
  logic             res_match_q;
  logic             res_match_d;
  logic             res_underflow_q;
  logic             res_underflow_d;
  logic             err_sticky_q;
  logic             err_sticky_d;
  logic [31:0]      tri_cnt_q;
  logic [31:0]      tri_cnt_d;
  logic             err_hit;

  always_comb begin
    res_valid_d     = close;
    res_cnt_d       = res_cnt_q;
    res_exp_d       = res_exp_q;
    res_match_d     = res_match_q;
    res_underflow_d = res_underflow_q;
    err_hit         = 1'b0;
    if (close) begin
      res_cnt_d       = close_cnt;
      res_exp_d       = fifo_empty ? '0 : head;
      res_match_d     = !fifo_empty && (close_cnt == head);
      res_underflow_d = fifo_empty;
      err_hit         = fifo_empty || (close_cnt != head);
    end
    err_sticky_d = err_sticky_q || err_hit;
    tri_cnt_d    = tri_cnt_q + 32'(close);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fill_q          <= '0;
      res_valid_q     <= 1'b0;
      res_cnt_q       <= '0;
      res_exp_q       <= '0;
      res_match_q     <= 1'b0;
      res_underflow_q <= 1'b0;
      err_sticky_q    <= 1'b0;
      tri_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      fill_q          <= fill_d;
      res_valid_q     <= res_valid_d;
      res_cnt_q       <= res_cnt_d;
      res_exp_q       <= res_exp_d;
      res_match_q     <= res_match_d;
      res_underflow_q <= res_underflow_d;
      err_sticky_q    <= err_sticky_d;
      tri_cnt_q       <= tri_cnt_d;
    end
  end

`ifdef SMPL_CNT_CHK_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  logic [15:0] err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_hit && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) err_cnt_q <= '0;
    else      err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

  assign bus.res_valid     = res_valid_q;
  assign bus.res_cnt       = res_cnt_q;
  assign bus.res_exp       = res_exp_q;
  assign bus.res_match     = res_match_q;
  assign bus.res_underflow = res_underflow_q;
  assign err_sticky        = err_sticky_q;
  assign tri_cnt           = tri_cnt_q;

endmodule

// File: tb/tb_smpl_cnt_chk.sv
// Bench for smpl_cnt_chk: directed scenarios with literal expectations plus a random run
// compared each cycle against a queue-based model; a CNT_W=4 instance checks saturation.
module tb_smpl_cnt_chk;

  localparam int P     = 3;
  localparam int DEPTH = 8;
  localparam longint unsigned MAXC = 64'hFFFF_FFFF;
`ifdef SMPL_CNT_CHK_ERR_CNT_EN
  localparam bit ERRC_EN = 1'b1;
`else
  localparam bit ERRC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst;
  logic signed [2:0][2:0][23:0] tri_in;
  logic                       vld;
  logic [1:0]                 hits;
  logic                       flush;
  logic                       err_sticky;
  logic [15:0]                err_cnt;
  logic [31:0]                tri_cnt;

  logic                       s_rst;
  logic signed [2:0][2:0][23:0] s_tri;
  logic                       s_vld;
  logic [1:0]                 s_hits;
  logic                       s_flush;
  logic                       s_err_sticky;
  logic [15:0]                s_err_cnt;
  logic [31:0]                s_tri_cnt;

  smpl_cnt_chk_if #(.CNT_W(32)) bus ();
  smpl_cnt_chk_if #(.CNT_W(4))  s_bus ();

  smpl_cnt_chk dut (
    .clk(clk), .rst(rst), .tri_R16S(tri_in), .validSamp_R16H(vld),
    .hit_valid_R18H(hits), .flush(flush), .bus(bus),
    .err_sticky(err_sticky), .err_cnt(err_cnt), .tri_cnt(tri_cnt)
  );

  smpl_cnt_chk #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(s_rst), .tri_R16S(s_tri), .validSamp_R16H(s_vld),
    .hit_valid_R18H(s_hits), .flush(s_flush), .bus(s_bus),
    .err_sticky(s_err_sticky), .err_cnt(s_err_cnt), .tri_cnt(s_tri_cnt)
  );

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: delay queues, expectation queue and an open/closed triangle tally
  logic [215:0]    m_tq[$];
  bit              m_vq[$];
  longint unsigned m_exp[$];
  bit              m_open;
  longint unsigned m_cnt;
  bit              e_valid;
  longint unsigned e_cnt;
  longint unsigned e_exp;
  bit              e_match;
  bit              e_uf;
  bit              m_sticky;
  longint unsigned m_errc;
  logic [31:0]     m_tric;

  function automatic longint unsigned sat(input longint unsigned v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic model_reset();
    m_tq.delete();
    m_vq.delete();
    for (int i = 0; i < P; i++) begin
      m_tq.push_back('0);
      m_vq.push_back(1'b0);
    end
    m_exp.delete();
    m_open = 0; m_cnt = 0;
    e_valid = 0; e_cnt = 0; e_exp = 0; e_match = 0; e_uf = 0;
    m_sticky = 0; m_errc = 0; m_tric = 0;
  endtask

  task automatic model_cycle();
    bit              b;
    bit              rdy;
    bit              cl;
    longint unsigned pc;
    longint unsigned cc;
    if (!rst) begin
      model_reset();
      return;
    end
    rdy = (m_exp.size() < DEPTH);
    b   = (m_tq[1] != m_tq[0]) && m_vq[0];
    pc  = longint'($countones(hits));
    cl  = 0;
    cc  = 0;
    if (m_open && b) begin
      cl = 1; cc = m_cnt; m_cnt = sat(pc);
    end else if (b) begin
      m_open = 1; m_cnt = sat(pc);
    end else if (m_open && flush) begin
      cl = 1; cc = sat(m_cnt + pc); m_open = 0; m_cnt = 0;
    end else if (m_open) begin
      m_cnt = sat(m_cnt + pc);
    end
    e_valid = cl;
    if (cl) begin
      e_uf    = (m_exp.size() == 0);
      e_exp   = e_uf ? 0 : m_exp.pop_front();
      e_cnt   = cc;
      e_match = !e_uf && (cc == e_exp);
      m_tric  = m_tric + 32'd1;
      if (!e_match) begin
        m_sticky = 1;
        if (ERRC_EN && m_errc < 64'hFFFF) m_errc++;
      end
    end
    if (bus.exp_valid && rdy) m_exp.push_back(longint'(bus.exp_cnt));
    m_tq.push_back(tri_in);
    void'(m_tq.pop_front());
    m_vq.push_back(vld);
    void'(m_vq.pop_front());
  endtask

  // One clock: check the combinational ready, advance model and DUT, compare registered outputs
  task automatic step();
    bit was_rst;
    #1;
    chk("exp_ready", 64'(bus.exp_ready), 64'(rst && (m_exp.size() < DEPTH)));
    was_rst = !rst;
    model_cycle();
    @(posedge clk);
    #1;
    chk("res_valid", 64'(bus.res_valid), 64'(e_valid));
    if (e_valid) begin
      chk("res_cnt", 64'(bus.res_cnt), 64'(e_cnt));
      chk("res_exp", 64'(bus.res_exp), 64'(e_exp));
      chk("res_match", 64'(bus.res_match), 64'(e_match));
      chk("res_underflow", 64'(bus.res_underflow), 64'(e_uf));
      txn++;
      $display("txn %0d: cnt=%0d exp=%0d match=%0b underflow=%0b tri_cnt=%0d",
               txn, bus.res_cnt, bus.res_exp, bus.res_match, bus.res_underflow, tri_cnt);
    end
    if (was_rst) begin
      chk("rst_res_cnt", 64'(bus.res_cnt), 64'd0);
      chk("rst_res_exp", 64'(bus.res_exp), 64'd0);
      chk("rst_res_flags", 64'({bus.res_match, bus.res_underflow}), 64'd0);
      chk("rst_exp_ready", 64'(bus.exp_ready), 64'd0);
    end
    chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
    chk("err_cnt", 64'(err_cnt), 64'(m_errc));
    chk("tri_cnt", 64'(tri_cnt), 64'(m_tric));
  endtask

  task automatic push(input logic [31:0] v);
    bus.exp_valid = 1'b1;
    bus.exp_cnt   = v;
    hits          = '0;
    step();
    bus.exp_valid = 1'b0;
  endtask

  // The boundary is seen P-1 cycles after the triangle changes; hits h land on that cycle.
  task automatic new_tri(input logic [215:0] v, input logic [1:0] h);
    tri_in = v;
    vld    = 1'b1;
    hits   = '0;
    flush  = 1'b0;
    repeat (P - 1) step();
    hits = h;
    step();
    hits = '0;
  endtask

  task automatic hit(input logic [1:0] h);
    hits = h;
    step();
    hits = '0;
  endtask

  task automatic do_flush(input logic [1:0] h);
    flush = 1'b1;
    hits  = h;
    step();
    flush = 1'b0;
    hits  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    hits = '0; flush = 1'b0; bus.exp_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    vld = 1'b1;
    step();
  endtask

  logic [215:0] tvals [4];

  initial begin
    rst = 1'b0; tri_in = '0; vld = 1'b0; hits = '0; flush = 1'b0;
    bus.exp_valid = 1'b0; bus.exp_cnt = '0;
    s_rst = 1'b0; s_tri = '0; s_vld = 1'b0; s_hits = '0; s_flush = 1'b0;
    s_bus.exp_valid = 1'b0; s_bus.exp_cnt = '0;
    for (int k = 0; k < 4; k++) begin
      tvals[k] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 24'($urandom)};
    end
    model_reset();

    do_reset();
    chk("reset_tri_cnt", 64'(tri_cnt), 64'd0);
    chk("reset_err_sticky", 64'(err_sticky), 64'd0);

    // Exp 5, hits 2,2,1 then flush
    push(32'd5);
    new_tri(216'h11, 2'b11);
    hit(2'b11);
    hit(2'b01);
    do_flush(2'b00);
    chk("t1_valid", 64'(bus.res_valid), 64'd1);
    chk("t1_cnt", 64'(bus.res_cnt), 64'd5);
    chk("t1_exp", 64'(bus.res_exp), 64'd5);
    chk("t1_match", 64'(bus.res_match), 64'd1);
    chk("t1_tri_cnt", 64'(tri_cnt), 64'd1);
    chk("t1_sticky", 64'(err_sticky), 64'd0);

    // Exp 3 and 4; A gets 3 hits, B opens with 2 on the boundary then flushes
    push(32'd3);
    push(32'd4);
    new_tri(216'h22, 2'b11);
    hit(2'b10);
    new_tri(216'h33, 2'b11);
    chk("t2a_cnt", 64'(bus.res_cnt), 64'd3);
    chk("t2a_match", 64'(bus.res_match), 64'd1);
    do_flush(2'b00);
    chk("t2b_cnt", 64'(bus.res_cnt), 64'd2);
    chk("t2b_exp", 64'(bus.res_exp), 64'd4);
    chk("t2b_match", 64'(bus.res_match), 64'd0);
    chk("t2b_sticky", 64'(err_sticky), 64'd1);
    chk("t2b_err_cnt", 64'(err_cnt), ERRC_EN ? 64'd1 : 64'd0);

    // Underflow on empty FIFO
    do_reset();
    new_tri(216'h44, 2'b01);
    do_flush(2'b00);
    chk("t3_underflow", 64'(bus.res_underflow), 64'd1);
    chk("t3_exp", 64'(bus.res_exp), 64'd0);
    chk("t3_match", 64'(bus.res_match), 64'd0);
    chk("t3_err_cnt", 64'(err_cnt), ERRC_EN ? 64'd1 : 64'd0);

    // Fill FIFO, dropped ninth push, pop frees a slot
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("t4_ready_open", 64'(bus.exp_ready), 64'd1);
      push(32'(10 + i));
    end
    #1;
    chk("t4_ready_full", 64'(bus.exp_ready), 64'd0);
    push(32'd99);
    new_tri(216'h55, 2'b01);
    do_flush(2'b00);
    chk("t4_pop_exp", 64'(bus.res_exp), 64'd10);
    #1;
    chk("t4_ready_after_pop", 64'(bus.exp_ready), 64'd1);

    // Reset in the middle of a triangle holding count 7
    do_reset();
    new_tri(216'h66, 2'b11);
    hit(2'b11);
    hit(2'b11);
    hit(2'b01);
    rst = 1'b0;
    step();
    chk("t5_no_result", 64'(bus.res_valid), 64'd0);
    chk("t5_tri_cnt", 64'(tri_cnt), 64'd0);
    chk("t5_res_cnt", 64'(bus.res_cnt), 64'd0);
    rst = 1'b1;
    step();
    new_tri(216'h77, 2'b01);
    do_flush(2'b00);
    chk("t5_fresh_cnt", 64'(bus.res_cnt), 64'd1);

    // Boundary on every cycle
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tri_in = tvals[i % 4];
      hits = 2'($urandom);
      bus.exp_valid = 1'b1;
      bus.exp_cnt = 32'($urandom_range(0, 2));
      step();
    end
    bus.exp_valid = 1'b0;

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) tri_in = tvals[$urandom_range(0, 3)];
      vld           = ($urandom_range(0, 9) != 0);
      hits          = 2'($urandom);
      flush         = ($urandom_range(0, 15) == 0);
      bus.exp_valid = ($urandom_range(0, 3) == 0);
      bus.exp_cnt   = 32'($urandom_range(0, 8));
      rst           = ($urandom_range(0, 499) != 0);
      step();
    end
    rst = 1'b1; hits = '0; flush = 1'b0; bus.exp_valid = 1'b0;

    // CNT_W=4 instance: 10 cycles of 2 hits saturate at 15
    s_rst = 1'b1;
    s_vld = 1'b1;
    step();
    s_tri[0][0] = 24'd1;
    repeat (P - 1) step();
    s_hits = 2'b11;
    repeat (10) step();
    s_hits = '0;
    s_flush = 1'b1;
    step();
    s_flush = 1'b0;
    chk("sat_valid", 64'(s_bus.res_valid), 64'd1);
    chk("sat_cnt", 64'(s_bus.res_cnt), 64'd15);
    chk("sat_underflow", 64'(s_bus.res_underflow), 64'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
